// File: rtl/idex_stage_if.sv
// ID/EX stage bus: upstream handshake, regfile read port, writeback snoop,
// flush and the latched execute-side fields. The stage uses the slave modport.
interface idex_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_pc;
   logic [31:0]       id_inst;
   logic [4:0]        rs1_addr;
   logic [4:0]        rs2_addr;
   logic [XLEN-1:0]   rs1_rdata;
   logic [XLEN-1:0]   rs2_rdata;
   logic              wb_we;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              flush;
   logic              ex_valid;
   logic              ex_ready;
   logic [XLEN-1:0]   ex_pc;
   logic [XLEN-1:0]   ex_rs1val;
   logic [XLEN-1:0]   ex_rs2val;
   logic [XLEN-1:0]   ex_imm;
   logic [4:0]        ex_rd;
   logic [3:0]        ex_alu_ctrl;
   logic [1:0]        ex_alu_src_a;
   logic [1:0]        ex_alu_src_b;
   logic              ex_mem_re;
   logic              ex_mem_we;
   logic              ex_reg_write;
   logic              ex_wb_sel;
   logic              ex_illegal;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  id_valid, id_pc, id_inst, rs1_rdata, rs2_rdata,
             wb_we, wb_rd, wb_data, flush, ex_ready,
      output id_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_rs1val,
             ex_rs2val, ex_imm, ex_rd, ex_alu_ctrl, ex_alu_src_a,
             ex_alu_src_b, ex_mem_re, ex_mem_we, ex_reg_write, ex_wb_sel,
             ex_illegal, stall_cnt
   );

   modport master (
      output id_valid, id_pc, id_inst, rs1_rdata, rs2_rdata,
             wb_we, wb_rd, wb_data, flush, ex_ready,
      input  id_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_rs1val,
             ex_rs2val, ex_imm, ex_rd, ex_alu_ctrl, ex_alu_src_a,
             ex_alu_src_b, ex_mem_re, ex_mem_we, ex_reg_write, ex_wb_sel,
             ex_illegal, stall_cnt
   );
endinterface

// File: rtl/idex_stage.sv
// RV32I ID/EX stage: decode, load-use/writeback hazard stall, flush, stall counter.
// Optional macro IDEX_WB_BYPASS_EN forwards a same-cycle writeback instead of stalling.
module idex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic        CLK,
   input  logic        RST,
   idex_stage_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [3:0]      alu_ctrl;
      logic [1:0]      alu_src_a;
      logic [1:0]      alu_src_b;
      logic            mem_re;
      logic            mem_we;
      logic            reg_write;
      logic            wb_sel;
      logic            illegal;
   } ctrl_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   function automatic logic [XLEN-1:0] imm_i(input logic [31:0] inst);
      return sext32({{20{inst[31]}}, inst[31:20]});
   endfunction

   function automatic logic [XLEN-1:0] imm_s(input logic [31:0] inst);
      return sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [31:0] inst);
      return sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
   endfunction

   function automatic logic [XLEN-1:0] imm_u(input logic [31:0] inst);
      return sext32({inst[31:12], 12'b0});
   endfunction

   function automatic logic [XLEN-1:0] imm_j(input logic [31:0] inst);
      return sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
   endfunction

   ctrl_t            dec_s;
   ctrl_t            ex_r;
   logic             ex_valid_r;
   logic [XLEN-1:0]  ex_rs1val_r;
   logic [XLEN-1:0]  ex_rs2val_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [6:0]       opcode_s;
   logic [2:0]       funct3_s;
   logic [4:0]       rs1_s;
   logic [4:0]       rs2_s;
   logic             use_rs1_s;
   logic             use_rs2_s;
   logic             lu_hazard_s;
   logic             wb_hazard_s;
   logic             hazard_s;
   logic             id_ready_s;
   logic [XLEN-1:0]  rs1val_s;
   logic [XLEN-1:0]  rs2val_s;

   assign opcode_s = bus.id_inst[6:0];
   assign funct3_s = bus.id_inst[14:12];
   assign rs1_s    = bus.id_inst[19:15];
   assign rs2_s    = bus.id_inst[24:20];
   assign bus.rs1_addr = rs1_s;
   assign bus.rs2_addr = rs2_s;

   assign use_rs1_s = (opcode_s == OP_JALR) | (opcode_s == OP_BRANCH) | (opcode_s == OP_LOAD) |
                      (opcode_s == OP_STORE) | (opcode_s == OP_IMM) | (opcode_s == OP_REG);
   assign use_rs2_s = (opcode_s == OP_REG) | (opcode_s == OP_STORE) | (opcode_s == OP_BRANCH);

   assign lu_hazard_s = ex_valid_r & ex_r.mem_re & (ex_r.rd != 5'd0) &
                        ((use_rs1_s & (ex_r.rd == rs1_s)) | (use_rs2_s & (ex_r.rd == rs2_s)));
   assign hazard_s    = lu_hazard_s | wb_hazard_s;
   assign id_ready_s  = bus.flush | (~hazard_s & (~ex_valid_r | bus.ex_ready));
   assign bus.id_ready = id_ready_s;

`ifdef IDEX_WB_BYPASS_EN
   // Forward a writeback that targets a register being read this cycle.
   always_comb begin
      wb_hazard_s = 1'b0;
      if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1_s)) begin
         rs1val_s = bus.wb_data;
      end else begin
         rs1val_s = bus.rs1_rdata;
      end
      if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2_s)) begin
         rs2val_s = bus.wb_data;
      end else begin
         rs2val_s = bus.rs2_rdata;
      end
   end
`else
   // Without forwarding, a writeback to a used source stalls one cycle for the regfile.
   always_comb begin
      rs1val_s    = bus.rs1_rdata;
      rs2val_s    = bus.rs2_rdata;
      wb_hazard_s = bus.wb_we & (bus.wb_rd != 5'd0) &
                    ((use_rs1_s & (bus.wb_rd == rs1_s)) | (use_rs2_s & (bus.wb_rd == rs2_s)));
   end
`endif

   // Instruction decode into the control fields latched by ID/EX.
   always_comb begin
      dec_s    = '0;
      dec_s.pc = bus.id_pc;
      dec_s.rd = bus.id_inst[11:7];
      case (opcode_s)
         OP_LUI: begin
            dec_s.imm = imm_u(bus.id_inst); dec_s.alu_src_a = 2'b10; dec_s.alu_src_b = 2'b01;
            dec_s.reg_write = 1'b1;
         end
         OP_AUIPC: begin
            dec_s.imm = imm_u(bus.id_inst); dec_s.alu_src_a = 2'b01; dec_s.alu_src_b = 2'b01;
            dec_s.reg_write = 1'b1;
         end
         OP_JAL: begin
            dec_s.imm = imm_j(bus.id_inst); dec_s.alu_src_a = 2'b01; dec_s.alu_src_b = 2'b10;
            dec_s.reg_write = 1'b1;
         end
         OP_JALR: begin
            dec_s.imm = imm_i(bus.id_inst); dec_s.alu_src_a = 2'b01; dec_s.alu_src_b = 2'b10;
            dec_s.reg_write = 1'b1;
         end
         OP_BRANCH: begin
            dec_s.imm = imm_b(bus.id_inst); dec_s.alu_ctrl = 4'b1000; dec_s.rd = 5'd0;
         end
         OP_LOAD: begin
            dec_s.imm = imm_i(bus.id_inst); dec_s.alu_src_b = 2'b01; dec_s.mem_re = 1'b1;
            dec_s.reg_write = 1'b1; dec_s.wb_sel = 1'b1;
         end
         OP_STORE: begin
            dec_s.imm = imm_s(bus.id_inst); dec_s.alu_src_b = 2'b01; dec_s.mem_we = 1'b1;
            dec_s.rd = 5'd0;
         end
         OP_IMM: begin
            // Only the right shifts carry funct7[5] (SRLI vs SRAI) into the ALU code.
            dec_s.imm = imm_i(bus.id_inst); dec_s.alu_src_b = 2'b01; dec_s.reg_write = 1'b1;
            if (funct3_s == 3'b101) begin
               dec_s.alu_ctrl = {bus.id_inst[30], funct3_s};
            end else begin
               dec_s.alu_ctrl = {1'b0, funct3_s};
            end
         end
         OP_REG: begin
            dec_s.alu_ctrl = {bus.id_inst[30], funct3_s}; dec_s.reg_write = 1'b1;
         end
         default: begin
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   // ID/EX register and stall counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_valid_r  <= 1'b0;
         ex_r        <= '0;
         ex_rs1val_r <= '0;
         ex_rs2val_r <= '0;
         stall_cnt_r <= '0;
      end else begin
         if (bus.flush) begin
            ex_valid_r <= 1'b0;
         end else if (hazard_s && bus.ex_ready) begin
            ex_valid_r <= 1'b0;
         end else if (bus.id_valid && id_ready_s) begin
            ex_valid_r  <= 1'b1;
            ex_r        <= dec_s;
            ex_rs1val_r <= rs1val_s;
            ex_rs2val_r <= rs2val_s;
         end else if (bus.ex_ready) begin
            ex_valid_r <= 1'b0;
         end else begin
            ex_valid_r <= ex_valid_r;
         end
         if (bus.id_valid && hazard_s && !bus.flush && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign bus.ex_valid     = ex_valid_r;
   assign bus.ex_pc        = ex_r.pc;
   assign bus.ex_rs1val    = ex_rs1val_r;
   assign bus.ex_rs2val    = ex_rs2val_r;
   assign bus.ex_imm       = ex_r.imm;
   assign bus.ex_rd        = ex_r.rd;
   assign bus.ex_alu_ctrl  = ex_r.alu_ctrl;
   assign bus.ex_alu_src_a = ex_r.alu_src_a;
   assign bus.ex_alu_src_b = ex_r.alu_src_b;
   assign bus.ex_mem_re    = ex_r.mem_re;
   assign bus.ex_mem_we    = ex_r.mem_we;
   assign bus.ex_reg_write = ex_r.reg_write;
   assign bus.ex_wb_sel    = ex_r.wb_sel;
   assign bus.ex_illegal   = ex_r.illegal;
   assign bus.stall_cnt    = stall_cnt_r;
endmodule
